// File: rtl/io_loader.sv
// Purpose : stream-to-RAM loader; buffers valid/ready words in a small FIFO and writes them
//           to consecutive RAM addresses from a programmable base for a programmable count.
// Latency : word accepted at edge k (empty FIFO, no stall) is written with write_enable=1 after edge k+1.
// Backpr. : data_ready drops when the FIFO is full or all words are accepted; ram_stall holds the FIFO.
//
// Ports:
//   clock, reset_n (sync, active-low)
//   start/base_addr/length/wrap_en : load command, sampled only when honoured in IDLE
//   data_in/data_valid/data_ready  : input word stream from the file reader
//   ram_stall                      : RAM port busy, no write may be issued
//   write_enable/data_to_ram/address : registered RAM write port
//   busy/done/overflow_err/words_written : status towards the control unit
module io_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  wrap_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  ram_stall,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_to_ram,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;   // next address to be written
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   acc_q, acc_d;             // words accepted this load
    logic [ADDR_WIDTH:0]   written_q, written_d;
    logic                  wrap_q, wrap_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // FIFO: pointers carry one extra bit to tell full from empty.
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, push, pop, last_write, overflow, fifo_clear;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

        // Deliberately ignores a same-cycle pop so ready never depends on ram_stall.
        data_ready = (state_q == LOAD) && !fifo_full && (acc_q < len_q);
        push       = data_valid && data_ready;
        pop        = (state_q == LOAD) && !fifo_empty && !ram_stall;
        last_write = pop && ((written_q + CNT_ONE) == len_q);
        // Writing the top address with words still to go and no wrap permitted.
        overflow   = pop && !last_write && !wrap_q && (cur_addr_q == ADDR_MAX);
        fifo_clear = ((state_q == IDLE) && start) || overflow;

        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        acc_d      = acc_q;
        written_d  = written_q;
        wrap_d     = wrap_q;
        we_d       = 1'b0;
        dat_d      = dat_q;
        addr_d     = addr_q;
        err_d      = err_q;
        // Status lags the state by one cycle, so done follows the final write cycle.
        busy_d     = (state_q == LOAD);
        done_d     = (state_q == DONE);

        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        if (fifo_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = length;
                    wrap_d     = wrap_en;
                    cur_addr_d = base_addr;
                    acc_d      = '0;
                    written_d  = '0;
                    err_d      = 1'b0;
                    state_d    = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (push) begin
                    acc_d = acc_q + CNT_ONE;
                end
                if (pop) begin
                    we_d       = 1'b1;
                    dat_d      = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
                    addr_d     = cur_addr_q;
                    cur_addr_d = cur_addr_q + ADDR_ONE;   // modulo wrap is natural
                    written_d  = written_q + CNT_ONE;
                    if (last_write) begin
                        state_d = DONE;
                    end else if (overflow) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            written_q  <= '0;
            wrap_q     <= 1'b0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            written_q  <= written_d;
            wrap_q     <= wrap_d;
            we_q       <= we_d;
            dat_q      <= dat_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= data_in;
        end
    end

    assign write_enable  = we_q;
    assign data_to_ram   = dat_q;
    assign address       = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow_err  = err_q;
    assign words_written = written_q;

endmodule

// File: tb/tb_io_loader.sv
module tb_io_loader;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset_n, start, wrap_en, data_valid, ram_stall;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] data_in;
    logic          data_ready, write_enable, busy, done, overflow_err;
    logic [DW-1:0] data_to_ram;
    logic [AW-1:0] address;
    logic [AW:0]   words_written;

    io_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .wrap_en(wrap_en), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .ram_stall(ram_stall), .write_enable(write_enable),
        .data_to_ram(data_to_ram), .address(address), .busy(busy), .done(done),
        .overflow_err(overflow_err), .words_written(words_written)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           exp_q[$];
    logic [AW-1:0] wlog[$];
    logic [AW-1:0] exp_log[$];
    logic [DW-1:0] src_q[$];

    // Model of the current load, expressed as word counts rather than states.
    int m_base, m_len, m_acc, m_written, m_target, done_cnt;
    bit m_ovf, m_in_load, m_prev_load, done_pending, lz_pending, chk_en, hs_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_base = 0; m_len = 0; m_acc = 0; m_written = 0; m_target = 0;
        m_ovf = 0; m_in_load = 0; m_prev_load = 0; done_pending = 0; lz_pending = 0;
        exp_q.delete(); wlog.delete();
    endtask

    task automatic model_start(input int b, input int l, input bit w);
        int room;
        room      = (1 << AW) - b;
        m_base    = b;
        m_len     = l;
        m_acc     = 0;
        m_written = 0;
        m_ovf     = !w && (l > room);
        m_target  = m_ovf ? room : l;
        m_in_load = (l != 0);
        lz_pending = (l == 0);
        done_pending = 0;
        exp_q.delete();
        wlog.delete();
    endtask

    // Called at posedge+1; the start is honoured on the next edge.
    task automatic do_start(input int b, input int l, input bit w);
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        wrap_en   = w;
        start     = 1'b1;
        @(posedge clock);
        model_start(b, l, w);
        #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_done(input string tag, output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(posedge clock); #1;
            n = i;
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(wlog[i]), 32'(exp_log[i]));
    endtask

    // Stream source: pops a word once the handshake seen before the edge completed.
    always @(negedge clock) hs_seen = data_valid && data_ready;
    always @(posedge clock) begin
        #1;
        if (hs_seen && src_q.size() > 0) void'(src_q.pop_front());
        hs_seen = 0;
        data_valid = (src_q.size() > 0);
        if (src_q.size() > 0) data_in = src_q[0];
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        bit exp_done, exp_rdy;
        wr_t e;
        if (chk_en) begin
            exp_done = done_pending;
            done_pending = 0;
            if (write_enable) begin
                wlog.push_back(address);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(address), 32'(e.a));
                    chk("wr_data", 32'(data_to_ram), 32'(e.d));
                end
                m_written++;
                if (m_written > m_target) chk("write_beyond_target", 32'(m_written), 32'(m_target));
                if (m_written == m_target) begin
                    done_pending = 1;
                    m_in_load = 0;
                end
            end
            chk("done", 32'(done), 32'(exp_done));
            if (done) done_cnt++;
            chk("busy", 32'(busy), 32'(m_prev_load));
            chk("words_written", 32'(words_written), 32'(m_written));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf && (m_written == m_target)));
            exp_rdy = m_in_load && ((m_acc - m_written) < DEPTH) && (m_acc < m_len);
            chk("data_ready", 32'(data_ready), 32'(exp_rdy));
            if (data_valid && data_ready) begin
                exp_q.push_back('{a: AW'(m_base + m_acc), d: data_in});
                m_acc++;
            end
            m_prev_load = m_in_load;
            if (lz_pending) begin
                done_pending = 1;
                lz_pending = 0;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_ready"},   32'(data_ready), 32'd0);
        chk({tag, "_write_enable"}, 32'(write_enable), 32'd0);
        chk({tag, "_data_to_ram"},  32'(data_to_ram), 32'd0);
        chk({tag, "_address"},      32'(address), 32'd0);
        chk({tag, "_busy"},         32'(busy), 32'd0);
        chk({tag, "_done"},         32'(done), 32'd0);
        chk({tag, "_overflow_err"}, 32'(overflow_err), 32'd0);
        chk({tag, "_words_written"},32'(words_written), 32'd0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n, d0;
        reset_n = 1'b0; start = 1'b0; ram_stall = 1'b0; data_valid = 1'b0;
        data_in = '0; base_addr = '0; length = '0; wrap_en = 1'b0;
        chk_en = 0; done_cnt = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        chk_en = 1;
        idle(2);

        // data_valid in IDLE is not accepted, then the basic load consumes it.
        src_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        idle(3);
        chk("idle_not_accepted", 32'(src_q.size()), 32'd4);
        d0 = done_cnt;
        do_start(32'h10, 4, 0);
        wait_done("basic", n);
        chk("basic_latency", 32'(n), 32'd6);
        chk("basic_words", 32'(words_written), 32'd4);
        chk("basic_ovf", 32'(overflow_err), 32'd0);
        chk("basic_last_data", 32'(data_to_ram), 32'hA4);
        exp_log = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_log("basic");
        idle(2);
        chk("basic_one_done", 32'(done_cnt - d0), 32'd1);

        // Backpressure: stalled RAM fills the FIFO after DEPTH accepts.
        src_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        ram_stall = 1'b1;
        do_start(32'h40, 8, 0);
        idle(9);
        chk("bp_accepts", 32'(m_acc), 32'd4);
        chk("bp_ready_low", 32'(data_ready), 32'd0);
        chk("bp_src_left", 32'(src_q.size()), 32'd4);
        chk("bp_no_write", 32'(words_written), 32'd0);
        ram_stall = 1'b0;
        wait_done("bp", n);
        chk("bp_words", 32'(words_written), 32'd8);
        chk("bp_last_data", 32'(data_to_ram), 32'hB7);
        exp_log = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        check_log("bp");
        idle(2);

        // Address wrap permitted.
        src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        do_start(32'hFE, 4, 1);
        wait_done("wrap", n);
        chk("wrap_words", 32'(words_written), 32'd4);
        chk("wrap_ovf", 32'(overflow_err), 32'd0);
        exp_log = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check_log("wrap");
        idle(2);

        // Address overflow aborts.
        src_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        do_start(32'hFE, 4, 0);
        wait_done("ovf", n);
        chk("ovf_words", 32'(words_written), 32'd2);
        chk("ovf_err", 32'(overflow_err), 32'd1);
        exp_log = '{8'hFE, 8'hFF};
        check_log("ovf");
        src_q.delete();
        idle(3);
        chk("ovf_err_sticky", 32'(overflow_err), 32'd1);

        // length=0: clears the sticky error, no writes, a single done.
        d0 = done_cnt;
        do_start(32'h00, 0, 0);
        chk("len0_err_cleared", 32'(overflow_err), 32'd0);
        wait_done("len0", n);
        chk("len0_latency", 32'(n), 32'd1);
        idle(3);
        chk("len0_no_write", 32'(wlog.size()), 32'd0);
        chk("len0_one_done", 32'(done_cnt - d0), 32'd1);

        // start during LOAD is ignored.
        src_q = '{8'hE0, 8'hE1, 8'hE2};
        do_start(32'h80, 3, 0);
        base_addr = 8'h20; length = 9'd5; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done("ign", n);
        chk("ign_words", 32'(words_written), 32'd3);
        exp_log = '{8'h80, 8'h81, 8'h82};
        check_log("ign");
        idle(2);

        // Reset in the middle of a load.
        src_q = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
        do_start(32'h30, 6, 0);
        begin
            bit seen2;
            seen2 = 0;
            for (int i = 0; i < 30 && !seen2; i++) begin
                @(posedge clock); #1;
                if (words_written == 9'd2) seen2 = 1;
            end
            chk("rst_two_writes_seen", 32'(seen2), 32'd1);
        end
        reset_n = 1'b0;
        chk_en = 0;
        src_q.delete();
        @(posedge clock); #1;
        check_reset_values("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("midrst_no_write", 32'(write_enable), 32'd0);
        end
        model_reset();
        reset_n = 1'b1;
        chk_en = 1;
        idle(2);

        src_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        do_start(32'h30, 6, 0);
        wait_done("after_rst", n);
        chk("after_rst_words", 32'(words_written), 32'd6);
        chk("after_rst_last_data", 32'(data_to_ram), 32'h55);
        exp_log = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        check_log("after_rst");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
